ns_pktcnt_snapshot_sched: RTL and testbench



---
 rtl/ns_pktcnt_snapshot_sched.sv | 149 ++++++++++++++
 tb/tb_ns_pktcnt_snapshot_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ns_pktcnt_snapshot_sched.sv
// rtl/ns_pktcnt_snapshot_sched.sv - snapshot scheduler serialising per-channel packet counters as one stream frame
module ns_pktcnt_snapshot_sched #(
  parameter int NCH           = 2,
  parameter int PERIOD_CYCLES = 250000000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NCH*192-1:0]   cnt_in,
  input  logic                 sw_trigger,
  output logic [63:0]          axis_tdata,
  output logic                 axis_tlast,
  output logic                 axis_tvalid,
  input  logic                 axis_tready,
  output logic                 busy,
  output logic [15:0]          seq,
  output logic [15:0]          overruns
);

  localparam int NW = 3 * NCH;
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] IDX_LAST = IW'(NW - 1);
  localparam logic [31:0] PER_LAST = (PERIOD_CYCLES > 0) ? 32'(PERIOD_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_DATA} state_t;

  state_t               state_q, state_d;
  logic [NCH*192-1:0]   shadow_q;
  logic [15:0]          hdr_seq_q;
  logic [31:0]          hdr_ts_q;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 pending_q, pending_d;
  logic [15:0]          seq_q, seq_d;
  logic [15:0]          overruns_q, overruns_d;
  logic [31:0]          timer_q, timer_d;
  logic [31:0]          ts_q;
  logic                 tick;
  logic                 trig;
  logic                 capture;
  logic                 last_hs;
  logic [63:0]          words [NW];

  // Word k of the data phase sits at bit k*64 because each channel packs its three fields contiguously.
  for (genvar k = 0; k < NW; k++) begin : g_words
    assign words[k] = shadow_q[k*64 +: 64];
  end

  assign tick    = (PERIOD_CYCLES != 0) && (timer_q == PER_LAST);
  assign trig    = sw_trigger | tick;
  assign last_hs = (state_q == SEND_DATA) && (idx_q == IDX_LAST) && axis_tready;

  assign timer_d = (PERIOD_CYCLES == 0 || tick) ? 32'd0 : timer_q + 32'd1;

  // Next-state, capture decision, pending/overrun bookkeeping.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    overruns_d = overruns_q;
    seq_d      = seq_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          capture = 1'b1;
          state_d = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (axis_tready) begin
          state_d = SEND_DATA;
          idx_d   = '0;
        end
      end
      SEND_DATA: begin
        if (axis_tready) begin
          if (idx_q == IDX_LAST) begin
            if (pending_q || trig) begin
              capture   = 1'b1;
              pending_d = 1'b0;
              state_d   = SEND_HDR;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A trigger coinciding with the final handshake is consumed by the back-to-back capture above.
    if (state_q != IDLE && trig && !last_hs) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (overruns_q != 16'hFFFF) begin
        overruns_d = overruns_q + 16'd1;
      end
    end
    if (capture) begin
      seq_d = seq_q + 16'd1;
    end
  end

  // State, counters and shadow registers; shadows only change on a capture edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      hdr_seq_q  <= '0;
      hdr_ts_q   <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      seq_q      <= '0;
      overruns_q <= '0;
      timer_q    <= '0;
      ts_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      seq_q      <= seq_d;
      overruns_q <= overruns_d;
      timer_q    <= timer_d;
      ts_q       <= ts_q + 32'd1;
      if (capture) begin
        shadow_q  <= cnt_in;
        hdr_seq_q <= seq_q;
        hdr_ts_q  <= ts_q;
      end
    end
  end

  // Stream outputs are pure functions of registered state, so they hold steady under backpressure.
  always_comb begin
    axis_tdata = 64'd0;
    case (state_q)
      SEND_HDR:  axis_tdata = {8'hA5, 8'(NCH), hdr_seq_q, hdr_ts_q};
      SEND_DATA: axis_tdata = words[idx_q];
      default:   axis_tdata = 64'd0;
    endcase
  end

  assign axis_tvalid = (state_q != IDLE);
  assign axis_tlast  = (state_q == SEND_DATA) && (idx_q == IDX_LAST);
  assign busy        = (state_q != IDLE);
  assign seq         = seq_q;
  assign overruns    = overruns_q;

endmodule

// File: tb/tb_ns_pktcnt_snapshot_sched.sv
// tb/tb_ns_pktcnt_snapshot_sched.sv - directed bench for ns_pktcnt_snapshot_sched
module tb_ns_pktcnt_snapshot_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         resetn0, sw0, tready0, tlast0, tvalid0, busy0;
    logic [383:0] cnt0;
    logic [63:0]  tdata0;
    logic [15:0]  seq0, ovr0;

    logic         resetn1, sw1, tready1, tlast1, tvalid1, busy1;
    logic [383:0] cnt1;
    logic [63:0]  tdata1;
    logic [15:0]  seq1, ovr1;

    int frames1;
    int frames0;

    ns_pktcnt_snapshot_sched #(.NCH(2), .PERIOD_CYCLES(0)) dut0 (
        .clk(clk), .resetn(resetn0), .cnt_in(cnt0), .sw_trigger(sw0),
        .axis_tdata(tdata0), .axis_tlast(tlast0), .axis_tvalid(tvalid0), .axis_tready(tready0),
        .busy(busy0), .seq(seq0), .overruns(ovr0)
    );

    ns_pktcnt_snapshot_sched #(.NCH(2), .PERIOD_CYCLES(100)) dut1 (
        .clk(clk), .resetn(resetn1), .cnt_in(cnt1), .sw_trigger(sw1),
        .axis_tdata(tdata1), .axis_tlast(tlast1), .axis_tvalid(tvalid1), .axis_tready(tready1),
        .busy(busy1), .seq(seq1), .overruns(ovr1)
    );

    function automatic logic [383:0] mk(input logic [63:0] l0, b0, o0, l1, b1, o1);
        return {o1, b1, l1, o0, b0, l0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic take0(input string tag, input logic [63:0] ed, input logic [63:0] mask, input logic el);
        int n;
        n = 0;
        while (tvalid0 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout wait expired after %0d cycles", tag, n);
        end
        chk({tag, "_v"}, 64'(tvalid0), 64'd1);
        chk({tag, "_d"}, tdata0 & mask, ed & mask);
        chk({tag, "_l"}, 64'(tlast0), 64'(el));
        tready0 = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain0(output int frames);
        frames = 0;
        tready0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (tvalid0 === 1'b1 && tlast0 === 1'b1) frames++;
            @(negedge clk);
        end
    endtask

    localparam logic [63:0] ALL = 64'hFFFFFFFF_FFFFFFFF;
    localparam logic [63:0] HI  = 64'hFFFFFFFF_00000000;

    initial begin
        resetn0 = 1'b0; resetn1 = 1'b0;
        sw0 = 1'b0; sw1 = 1'b0;
        tready0 = 1'b1; tready1 = 1'b1;
        cnt0 = mk(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6);
        cnt1 = mk(64'd11, 64'd12, 64'd13, 64'd14, 64'd15, 64'd16);
        repeat (3) @(negedge clk);

        chk("rst_tvalid", 64'(tvalid0), 64'd0);
        chk("rst_tlast", 64'(tlast0), 64'd0);
        chk("rst_tdata", tdata0, 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_seq", 64'(seq0), 64'd0);
        chk("rst_ovr", 64'(ovr0), 64'd0);
        chk("rst_tvalid1", 64'(tvalid1), 64'd0);

        resetn1 = 1'b1;
        frames1 = 0;
        for (int c = 1; c <= 460; c++) begin
            @(negedge clk);
            if (c == 99)  chk("tmr_early", 64'(tvalid1), 64'd0);
            if (c == 100) chk("tmr_hdr0", tdata1, {8'hA5, 8'h02, 16'h0000, 32'd99});
            if (c == 106) chk("tmr_tlast", 64'(tlast1), 64'd1);
            if (c == 107) chk("tmr_end", 64'(tvalid1), 64'd0);
            if (c == 200) chk("tmr_hdr1", tdata1, {8'hA5, 8'h02, 16'h0001, 32'd199});
            if (c == 300) chk("tmr_hdr2", tdata1, {8'hA5, 8'h02, 16'h0002, 32'd299});
            if (c == 399) sw1 = 1'b1;
            if (c == 400) begin
                sw1 = 1'b0;
                chk("sim_hdr", tdata1, {8'hA5, 8'h02, 16'h0003, 32'd399});
            end
            if (c >= 400 && tvalid1 === 1'b1 && tlast1 === 1'b1) frames1++;
            if (c == 410) chk("sim_idle", 64'(tvalid1), 64'd0);
        end
        chk("sim_frames", 64'(frames1), 64'd1);
        chk("sim_seq", 64'(seq1), 64'd4);
        chk("sim_ovr", 64'(ovr1), 64'd0);

        resetn0 = 1'b1;
        repeat (10) @(negedge clk);
        sw0 = 1'b1;
        @(negedge clk);
        sw0 = 1'b0;
        take0("t1_w0", 64'hA5020000_0000000A, ALL, 1'b0);
        take0("t1_w1", 64'd1, ALL, 1'b0);
        take0("t1_w2", 64'd2, ALL, 1'b0);
        tready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_stall_d", tdata0, 64'd3);
            chk("t1_stall_v", 64'(tvalid0), 64'd1);
        end
        take0("t1_w3", 64'd3, ALL, 1'b0);
        take0("t1_w4", 64'd4, ALL, 1'b0);
        take0("t1_w5", 64'd5, ALL, 1'b0);
        take0("t1_w6", 64'd6, ALL, 1'b1);
        chk("t1_busy", 64'(busy0), 64'd0);
        chk("t1_seq", 64'(seq0), 64'd1);
        chk("t1_idle", 64'(tvalid0), 64'd0);

        tready0 = 1'b0;
        sw0 = 1'b1;
        @(negedge clk);
        sw0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sw0 = 1'b1;
            @(negedge clk);
            sw0 = 1'b0;
            @(negedge clk);
        end
        chk("t3_ovr", 64'(ovr0), 64'd2);
        chk("t3_busy", 64'(busy0), 64'd1);
        take0("t3_h", {8'hA5, 8'h02, 16'h0001, 32'd0}, HI, 1'b0);
        for (int k = 1; k <= 5; k++) take0("t3_a", 64'(k), ALL, 1'b0);
        cnt0 = mk(64'h100, 64'h101, 64'h102, 64'h103, 64'h104, 64'h105);
        take0("t3_a6", 64'd6, ALL, 1'b1);
        chk("t3_b2b_v", 64'(tvalid0), 64'd1);
        take0("t3_h2", {8'hA5, 8'h02, 16'h0002, 32'd0}, HI, 1'b0);
        for (int k = 0; k < 5; k++) take0("t3_b", 64'h100 + 64'(k), ALL, 1'b0);
        take0("t3_b5", 64'h105, ALL, 1'b1);
        chk("t3_seq", 64'(seq0), 64'd3);
        chk("t3_ovr2", 64'(ovr0), 64'd2);
        chk("t3_idle", 64'(tvalid0), 64'd0);

        sw0 = 1'b1;
        @(negedge clk);
        sw0 = 1'b0;
        take0("t5_h", {8'hA5, 8'h02, 16'h0003, 32'd0}, HI, 1'b0);
        take0("t5_w1", 64'h100, ALL, 1'b0);
        resetn0 = 1'b0;
        @(negedge clk);
        chk("t5_tvalid", 64'(tvalid0), 64'd0);
        chk("t5_tlast", 64'(tlast0), 64'd0);
        chk("t5_busy", 64'(busy0), 64'd0);
        chk("t5_seq", 64'(seq0), 64'd0);
        chk("t5_ovr", 64'(ovr0), 64'd0);
        resetn0 = 1'b1;
        sw0 = 1'b1;
        @(negedge clk);
        sw0 = 1'b0;
        take0("t5_h2", 64'hA5020000_00000000, ALL, 1'b0);
        for (int k = 0; k < 5; k++) take0("t5_b", 64'h100 + 64'(k), ALL, 1'b0);
        take0("t5_b5", 64'h105, ALL, 1'b1);

        force dut0.seq_q = 16'hFFFF;
        @(negedge clk);
        release dut0.seq_q;
        chk("t6_seq_pre", 64'(seq0), 64'hFFFF);
        sw0 = 1'b1;
        @(negedge clk);
        sw0 = 1'b0;
        chk("t6_hdr_seq", 64'(tdata0[63:32]), 64'hA502FFFF);
        chk("t6_seq_wrap", 64'(seq0), 64'h0000);

        tready0 = 1'b0;
        sw0 = 1'b1;
        @(negedge clk);
        sw0 = 1'b0;
        @(negedge clk);
        force dut0.overruns_q = 16'hFFFE;
        @(negedge clk);
        release dut0.overruns_q;
        for (int i = 0; i < 3; i++) begin
            sw0 = 1'b1;
            @(negedge clk);
            sw0 = 1'b0;
            @(negedge clk);
        end
        chk("t6_ovr_sat", 64'(ovr0), 64'hFFFF);
        drain0(frames0);
        chk("t6_frames", 64'(frames0), 64'd2);
        chk("t6_busy", 64'(busy0), 64'd0);
        chk("t6_seq_end", 64'(seq0), 64'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
